// File: rtl/axis_pkg.sv
// Shared widths for the AXI4-Stream master handshake block.
package axis_pkg;
  localparam int AXIS_DATA_WIDTH = 256;
  localparam int AXIS_CNT_WIDTH  = 32;
endpackage

// File: rtl/event_counter.sv
// Registered event counter: counts cycles with inc=1, wraps modulo 2^WIDTH.
module event_counter #(
  parameter int WIDTH = axis_pkg::AXIS_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/axi4s_master_handshake_data.sv
// AXI4-Stream master fed by a valid-only upstream, buffered by a two-entry
// skid buffer (output register + skid register), with transfer/drop counters.
module axi4s_master_handshake_data
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int CNT_WIDTH  = AXIS_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  datavalid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_ready;

  logic w_accept;
  logic w_xfer;
  logic w_drop;

  assign w_accept = datavalid & r_ready;
  assign w_xfer   = r_tvalid & tready;
  // Only a full buffer discards data; the ready=0 cycle right after reset
  // is reset recovery and is not counted.
  assign w_drop   = datavalid & r_skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b0;
    end else if (w_accept && (!r_tvalid || w_xfer)) begin
      r_tdata  <= data;
      r_tvalid <= 1'b1;
      r_ready  <= 1'b1;
    end else if (w_accept) begin
      r_skid_data  <= data;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end else if (w_xfer && r_skid_valid) begin
      r_tdata      <= r_skid_data;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_xfer) begin
      r_tvalid <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_ready <= ~r_skid_valid;
    end
  end

  assign ready  = r_ready;
  assign tdata  = r_tdata;
  assign tvalid = r_tvalid;

  event_counter #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_xfer),
    .count (cnt)
  );

  event_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_drop),
    .count (drop_cnt)
  );
endmodule

// File: tb/tb_axi4s_master_handshake_data.sv
// Randomised and directed bench for axi4s_master_handshake_data against a
// queue-based reference model of a two-deep FIFO stream buffer.
module tb_axi4s_master_handshake_data;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          datavalid;
  logic [DW-1:0] data;
  logic          tready;
  logic          ready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] drop_cnt;

  axi4s_master_handshake_data #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .datavalid (datavalid),
    .data      (data),
    .ready     (ready),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tready    (tready),
    .cnt       (cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: buffer of at most two entries, head is what is on tdata.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] sb_q[$];
  bit            m_rdy;
  bit            m_acc_last;
  bit            m_in_reset;
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_drop;
  int            n_acc;
  int            n_xfer;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit xf, ac, dr;
    m_in_reset = reset;
    m_acc_last = 1'b0;
    if (reset) begin
      m_q.delete();
      sb_q.delete();
      m_rdy  = 1'b0;
      m_cnt  = '0;
      m_drop = '0;
      n_acc  = 0;
      n_xfer = 0;
    end else begin
      xf = (m_q.size() > 0) && tready;
      ac = datavalid && m_rdy;
      dr = datavalid && (m_q.size() == 2);
      if (xf) begin
        void'(m_q.pop_front());
        m_cnt++;
        n_xfer++;
      end
      if (ac) begin
        m_q.push_back(data);
        sb_q.push_back(data);
        n_acc++;
      end
      if (dr) m_drop++;
      m_acc_last = ac;
      m_rdy = (m_q.size() < 2);
    end
  endtask

  task automatic step();
    if (!reset && tvalid && tready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_xfer", 64'd1, 64'd0);
      end else begin
        chk("sb_order", tdata, sb_q.pop_front());
        $display("xfer data=%0h cnt=%0d", tdata, cnt);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", ready, m_rdy);
    chk("tvalid", tvalid, m_q.size() > 0);
    chk("cnt", cnt, m_cnt);
    chk("drop_cnt", drop_cnt, m_drop);
    if (m_q.size() > 0) chk("tdata", tdata, m_q[0]);
    else if (m_in_reset) chk("tdata_reset", tdata, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    datavalid = 1'b0;
    tready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    bit seen_first;
    reset = 1'b1;
    datavalid = 1'b0;
    data = '0;
    tready = 1'b0;
    m_rdy = 1'b0;
    m_cnt = '0;
    m_drop = '0;
    n_acc = 0;
    n_xfer = 0;

    // Reset state
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_drop", drop_cnt, 0);

    // Streaming from reset release: 1, 2, 3, ... one per cycle
    datavalid = 1'b1;
    data = 1;
    tready = 1'b1;
    reset = 1'b0;
    step();
    chk("ready_after_release", ready, 1);
    seen_first = 1'b0;
    guard = 0;
    while (n_xfer < 100 && guard < 300) begin
      step();
      if (m_acc_last) data = data + 1;
      if (tvalid && !seen_first) begin
        seen_first = 1'b1;
        chk("first_word", tdata, 1);
      end
      guard++;
    end
    chk("stream_timeout", guard < 300, 1);
    chk("stream_cnt100", cnt, 100);
    chk("stream_drop0", drop_cnt, 0);

    // Stall with tready=0 for five offered words, then release
    do_reset();
    step();
    datavalid = 1'b1;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data = 32'h101 + i;
      step();
      chk("stall_tdata_hold", tdata, 32'h101);
      if (i == 1) chk("stall_ready_low", ready, 0);
    end
    chk("stall_drop3", drop_cnt, 3);
    datavalid = 1'b0;
    tready = 1'b1;
    step();
    chk("release_word2_tdata", tdata, 32'h102);
    chk("release_word2_tvalid", tvalid, 1);
    chk("release_ready", ready, 1);
    step();
    chk("release_empty", tvalid, 0);
    chk("release_cnt2", cnt, 2);

    // Reset with both registers full
    do_reset();
    step();
    datavalid = 1'b1;
    tready = 1'b0;
    data = 32'h201;
    step();
    data = 32'h202;
    step();
    chk("full_ready", ready, 0);
    reset = 1'b1;
    data = 32'h203;
    step();
    chk("rstfull_tvalid", tvalid, 0);
    chk("rstfull_ready", ready, 0);
    chk("rstfull_cnt", cnt, 0);
    chk("rstfull_drop", drop_cnt, 0);
    reset = 1'b0;
    data = 32'h204;
    step();
    step();
    datavalid = 1'b0;
    chk("rstfull_first_tdata", tdata, 32'h204);
    chk("rstfull_first_tvalid", tvalid, 1);
    chk("rstfull_nodrop", drop_cnt, 0);
    tready = 1'b1;
    step();

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      datavalid = $urandom_range(0, 3) != 0;
      tready = $urandom_range(0, 2) != 0;
      data = $urandom;
      step();
    end
    reset = 1'b0;
    datavalid = 1'b0;
    tready = 1'b0;
    step();
    chk("cnt_plus_pending", (cnt + m_q.size()) % 256, n_acc % 256);

    // Counter wrap: bring both counters to 255, then one transfer and one drop
    do_reset();
    datavalid = 1'b1;
    tready = 1'b1;
    data = 1;
    guard = 0;
    while (cnt != 8'hFF && guard < 600) begin
      step();
      if (m_acc_last) data = data + 1;
      guard++;
    end
    chk("wrap_cnt_timeout", guard < 600, 1);
    tready = 1'b0;
    guard = 0;
    while (drop_cnt != 8'hFF && guard < 600) begin
      step();
      guard++;
    end
    chk("wrap_drop_timeout", guard < 600, 1);
    chk("wrap_pre_cnt", cnt, 8'hFF);
    tready = 1'b1;
    step();
    chk("wrap_cnt0", cnt, 0);
    chk("wrap_drop0", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
